two_sum_streamer: RTL and testbench
===================================

Name: two_sum_streamer

Overview:
- Transmit-side companion of the streaming two-sum solver.
- Buffers an integer array loaded over a simple write interface, then replays it on start as a number/valid/last stream with a constant target.
- Captures the solver's index result and reports done/found with the captured indices.
- Sits between the host/test controller and the solver.

Parameters:
DATA_WIDTH, 2, signed element and target width
ARRAY_SIZE, 2**DATA_WIDTH, buffer depth and maximum array length
RESULT_WAIT, 2, cycles after the last beat during which a solver result is still accepted

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
load_data  in  DATA_WIDTH  signed element to store
load_valid  in  1  write load_data at the next buffer slot
load_last  in  1  marks the final element of the array (qualified by load_valid)
start  in  1  request to stream the loaded array
target_in  in  DATA_WIDTH  target sampled on the accepted start
number  out  DATA_WIDTH  streamed element
number_valid  out  1  stream beat valid
number_last  out  1  final beat of the array
target  out  DATA_WIDTH  latched target, held stable from the first beat through done
index1_in  in  $clog2(ARRAY_SIZE)  solver index1
index2_in  in  $clog2(ARRAY_SIZE)  solver index2
index_in_valid  in  1  solver result valid
busy  out  1  high in STREAM or WAIT
done  out  1  one-cycle pulse when a run ends
found  out  1  a result was captured in the last run
result_index1  out  $clog2(ARRAY_SIZE)  captured index1
result_index2  out  $clog2(ARRAY_SIZE)  captured index2
length  out  $clog2(ARRAY_SIZE)+1  number of elements loaded (0 = none)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; wr_ptr=0, length=0, loaded=0.
  - All outputs 0, including target, found and result indices.
  - Buffer contents are don't-care.
  - A reset mid-stream aborts the run with no done pulse.
- All outputs are registered.
- States and transitions:
  - IDLE -> STREAM: start=1, loaded=1, load_valid=0.
  - STREAM -> WAIT: on the beat with number_last.
  - WAIT -> DONE: after RESULT_WAIT cycles, or earlier on a captured result.
  - DONE -> IDLE: after one cycle.
- Load (IDLE only; ignored in other states):
  - Each load_valid writes buffer[wr_ptr] and increments wr_ptr.
  - On load_last, or when wr_ptr==ARRAY_SIZE-1: length=wr_ptr+1, loaded=1, wr_ptr=0.
  - The first load after loaded=1 clears loaded and starts a new array at slot 0.
- Start:
  - Accepted only in IDLE with loaded=1 and load_valid=0.
  - Load has priority when simultaneous with start; the start is dropped.
  - Start with loaded=0 is ignored.
  - On acceptance: target<=target_in, found<=0, result indices<=0, rd_ptr<=0.
- STREAM:
  - The first beat is visible in the cycle after the accepted start.
  - One beat per cycle, no stall: number=buffer[rd_ptr], number_valid=1.
  - number_last=1 exactly when rd_ptr==length-1.
  - Length 1 gives a single beat with valid and last both high.
- Streaming always runs to the last beat, even after a result is captured, so the solver's index counter and cache return to zero.
- Capture:
  - Window runs from the first beat through the end of WAIT.
  - The first cycle with index_in_valid=1 latches index1_in/index2_in and sets found=1.
  - Later assertions in the same run are ignored.
  - index_in_valid outside the window is ignored.
- WAIT:
  - number_valid=0, number_last=0.
  - Exits early to DONE if found=1 (including a capture in the WAIT cycle itself).
  - Otherwise exits after RESULT_WAIT cycles.
- DONE:
  - done=1 for one cycle; busy=0.
  - found and result indices hold until the next accepted start.
  - loaded stays 1, so start replays the same array.
- Width rules:
  - rd_ptr/wr_ptr are $clog2(ARRAY_SIZE) bits; no wrap beyond length-1.
  - length is one bit wider so it can represent ARRAY_SIZE.

Decomposition:
- Shared package two_sum_pkg:
  - DATA_WIDTH/ARRAY_SIZE defaults and the derived index width.
  - Streamer state encoding (IDLE, STREAM, WAIT, DONE).
  - Both the solver and the streamer use it.
- One sub-module: two_sum_array_buffer.
  - ARRAY_SIZE x DATA_WIDTH register file.
  - One synchronous write port, one combinational read port.
  - No reset on storage.

Test Plan:
- Load [1,0,-2,-1] (load_last on -1), start with target_in=1, bench solver model:
  - Beats 1,0,-2,-1 on four consecutive cycles, last only on -1, target=1 throughout.
  - Result 1/0 captured.
  - done pulses once, with found=1, result_index1=1, result_index2=0.
- Load [1,1,1,1], target_in=-2:
  - Full four-beat stream, RESULT_WAIT idle cycles.
  - done with found=0 and indices 0.
  - length=4, set by reaching ARRAY_SIZE without load_last.
- Load single element [0] with load_last, start, target_in=0:
  - One beat with valid=last=1, then done with found=0.
- Start before any load:
  - No beats, busy stays 0.
- Same cycle start=1 and load_valid=1:
  - Element stored, start ignored.
- After a completed run, start again with target_in=-1:
  - Same array replayed unchanged.
  - Solver asserts index_in_valid on beats 2 and 3; only the first is latched.
- rst=0 asserted asynchronously during beat 2:
  - number_valid, busy, done and found drop immediately.
  - length=0.
  - A subsequent start is ignored until a reload.

Source files
------------

// File: rtl/two_sum_pkg.sv
// Shared definitions for the streaming two-sum solver and its streamer.
// Holds default sizes, the derived index width and the streamer state encoding.
package two_sum_pkg;

  localparam int TS_DATA_WIDTH = 2;
  localparam int TS_ARRAY_SIZE = 2 ** TS_DATA_WIDTH;
  localparam int TS_IDX_W      = $clog2(TS_ARRAY_SIZE);

  typedef logic [TS_IDX_W-1:0] ts_idx_t;
  typedef logic [1:0]          ts_state_t;

  localparam ts_state_t ST_IDLE   = 2'd0;
  localparam ts_state_t ST_STREAM = 2'd1;
  localparam ts_state_t ST_WAIT   = 2'd2;
  localparam ts_state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/two_sum_array_buffer.sv
// Array storage for the streamer: one synchronous write port,
// one combinational read port, no reset on contents.
module two_sum_array_buffer
  import two_sum_pkg::*;
#(
  parameter int DATA_WIDTH = TS_DATA_WIDTH,
  parameter int DEPTH      = TS_ARRAY_SIZE
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/two_sum_streamer.sv
// Transmit side of the two-sum solver: buffers an array, replays it
// as a number/valid/last stream and captures the solver's result.
module two_sum_streamer
  import two_sum_pkg::*;
#(
  parameter int DATA_WIDTH  = TS_DATA_WIDTH,
  parameter int ARRAY_SIZE  = 2 ** DATA_WIDTH,
  parameter int RESULT_WAIT = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         load_data,
  input  logic                          load_valid,
  input  logic                          load_last,
  input  logic                          start,
  input  logic [DATA_WIDTH-1:0]         target_in,
  output logic [DATA_WIDTH-1:0]         number,
  output logic                          number_valid,
  output logic                          number_last,
  output logic [DATA_WIDTH-1:0]         target,
  input  logic [$clog2(ARRAY_SIZE)-1:0] index1_in,
  input  logic [$clog2(ARRAY_SIZE)-1:0] index2_in,
  input  logic                          index_in_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          found,
  output logic [$clog2(ARRAY_SIZE)-1:0] result_index1,
  output logic [$clog2(ARRAY_SIZE)-1:0] result_index2,
  output logic [$clog2(ARRAY_SIZE):0]   length
);

  localparam int IW = $clog2(ARRAY_SIZE);
  localparam int LW = IW + 1;
  localparam int WW = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;

  ts_state_t             state_q, state_d;
  logic [IW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [IW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         length_q, length_d;
  logic                  loaded_q, loaded_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;
  logic                  found_q, found_d;
  logic [IW-1:0]         idx1_q, idx1_d;
  logic [IW-1:0]         idx2_q, idx2_d;
  logic [DATA_WIDTH-1:0] number_q, number_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  load_we;
  logic                  start_ok;
  logic                  capture;
  logic [IW-1:0]         rd_next;
  logic                  last_next;
  logic [DATA_WIDTH-1:0] rdata;

  assign load_we  = (state_q == ST_IDLE) && load_valid;
  assign start_ok = (state_q == ST_IDLE) && start
                  && loaded_q && !load_valid;
  assign capture  = ((state_q == ST_STREAM) || (state_q == ST_WAIT))
                  && index_in_valid && !found_q;

  // Read address looks one beat ahead so the registered beat is ready
  assign rd_next   = (state_q == ST_IDLE) ? '0 : rd_ptr_q + IW'(1);
  assign last_next = ({1'b0, rd_next} == (length_q - LW'(1)));

  two_sum_array_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (ARRAY_SIZE)
  ) u_buf (
    .clk     (clk),
    .we_i    (load_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (load_data),
    .raddr_i (rd_next),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    length_d = length_q;
    loaded_d = loaded_q;
    wait_d   = wait_q;
    target_d = target_q;
    found_d  = found_q;
    idx1_d   = idx1_q;
    idx2_d   = idx2_q;
    number_d = number_q;
    valid_d  = valid_q;
    last_d   = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_we) begin
          wr_ptr_d = wr_ptr_q + IW'(1);
          loaded_d = 1'b0;
          if (load_last || (wr_ptr_q == IW'(ARRAY_SIZE - 1))) begin
            length_d = LW'(wr_ptr_q) + LW'(1);
            loaded_d = 1'b1;
            wr_ptr_d = '0;
          end
        end else if (start_ok) begin
          state_d  = ST_STREAM;
          target_d = target_in;
          found_d  = 1'b0;
          idx1_d   = '0;
          idx2_d   = '0;
          rd_ptr_d = '0;
          number_d = rdata;
          valid_d  = 1'b1;
          last_d   = last_next;
        end
      end
      ST_STREAM: begin
        if (last_q) begin
          state_d  = ST_WAIT;
          number_d = '0;
          valid_d  = 1'b0;
          last_d   = 1'b0;
          wait_d   = '0;
        end else begin
          rd_ptr_d = rd_next;
          number_d = rdata;
          last_d   = last_next;
        end
      end
      ST_WAIT: begin
        if (found_q || capture
            || (wait_q == WW'(RESULT_WAIT - 1))) begin
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase
    if (capture) begin
      found_d = 1'b1;
      idx1_d  = index1_in;
      idx2_d  = index2_in;
    end
  end

  assign busy_d = (state_d == ST_STREAM) || (state_d == ST_WAIT);
  assign done_d = (state_d == ST_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      length_q <= '0;
      loaded_q <= 1'b0;
      wait_q   <= '0;
      target_q <= '0;
      found_q  <= 1'b0;
      idx1_q   <= '0;
      idx2_q   <= '0;
      number_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      length_q <= length_d;
      loaded_q <= loaded_d;
      wait_q   <= wait_d;
      target_q <= target_d;
      found_q  <= found_d;
      idx1_q   <= idx1_d;
      idx2_q   <= idx2_d;
      number_q <= number_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign number        = number_q;
  assign number_valid  = valid_q;
  assign number_last   = last_q;
  assign target        = target_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign found         = found_q;
  assign result_index1 = idx1_q;
  assign result_index2 = idx2_q;
  assign length        = length_q;

endmodule

// File: tb/tb_two_sum_streamer.sv
// Scoreboard bench for two_sum_streamer: directed loads/starts push expected
// beats and results; a negedge monitor pops and compares them.
module tb_two_sum_streamer;

  logic       clk;
  logic       rst;
  logic [1:0] load_data;
  logic       load_valid;
  logic       load_last;
  logic       start;
  logic [1:0] target_in;
  logic [1:0] number;
  logic       number_valid;
  logic       number_last;
  logic [1:0] target;
  logic [1:0] index1_in;
  logic [1:0] index2_in;
  logic       index_in_valid;
  logic       busy;
  logic       done;
  logic       found;
  logic [1:0] result_index1;
  logic [1:0] result_index2;
  logic [2:0] length;

  two_sum_streamer #(
    .DATA_WIDTH  (2),
    .ARRAY_SIZE  (4),
    .RESULT_WAIT (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .load_data      (load_data),
    .load_valid     (load_valid),
    .load_last      (load_last),
    .start          (start),
    .target_in      (target_in),
    .number         (number),
    .number_valid   (number_valid),
    .number_last    (number_last),
    .target         (target),
    .index1_in      (index1_in),
    .index2_in      (index2_in),
    .index_in_valid (index_in_valid),
    .busy           (busy),
    .done           (done),
    .found          (found),
    .result_index1  (result_index1),
    .result_index2  (result_index2),
    .length         (length)
  );

  typedef struct {
    logic [1:0] num;
    logic       last;
    logic [1:0] tgt;
  } beat_t;

  typedef struct {
    logic       fnd;
    logic [1:0] i1;
    logic [1:0] i2;
  } res_t;

  beat_t exp_beats[$];
  res_t  exp_res[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int done_cyc = 0;

  int         hit_beat [2];
  logic [1:0] hit_i1   [2];
  logic [1:0] hit_i2   [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every beat and every done pulse with the scoreboard
  initial begin
    beat_t e;
    res_t  r;
    forever begin
      @(negedge clk);
      cyc++;
      if (number_valid) begin
        if (exp_beats.size() == 0) begin
          chk("unexpected_beat", int'(number_valid), 0);
        end else begin
          e = exp_beats.pop_front();
          chk("beat_number", int'(number), int'(e.num));
          chk("beat_last", int'(number_last), int'(e.last));
          chk("beat_target", int'(target), int'(e.tgt));
        end
        if (number_last) last_cyc = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        if (exp_res.size() == 0) begin
          chk("unexpected_done", int'(done), 0);
        end else begin
          r = exp_res.pop_front();
          chk("done_found", int'(found), int'(r.fnd));
          chk("done_index1", int'(result_index1), int'(r.i1));
          chk("done_index2", int'(result_index2), int'(r.i2));
          chk("done_busy", int'(busy), 0);
        end
      end
    end
  end

  // Solver model: raises index_in_valid for one cycle on chosen beats
  initial begin
    int sbeat;
    sbeat = 0;
    index_in_valid = 1'b0;
    index1_in = '0;
    index2_in = '0;
    forever begin
      @(negedge clk);
      index_in_valid = 1'b0;
      if (number_valid) begin
        for (int k = 0; k < 2; k++) begin
          if (sbeat == hit_beat[k]) begin
            index_in_valid = 1'b1;
            index1_in = hit_i1[k];
            index2_in = hit_i2[k];
          end
        end
        sbeat++;
      end else begin
        sbeat = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hits(input int b0, input logic [1:0] a0,
                          input logic [1:0] c0, input int b1,
                          input logic [1:0] a1, input logic [1:0] c1);
    hit_beat[0] = b0; hit_i1[0] = a0; hit_i2[0] = c0;
    hit_beat[1] = b1; hit_i1[1] = a1; hit_i2[1] = c1;
  endtask

  task automatic load_elem(input logic [1:0] d, input logic l);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = l;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic push_beat(input logic [1:0] n, input logic l,
                           input logic [1:0] t);
    beat_t b;
    b.num = n; b.last = l; b.tgt = t;
    exp_beats.push_back(b);
  endtask

  task automatic push_res(input logic f, input logic [1:0] a,
                          input logic [1:0] c);
    res_t r;
    r.fnd = f; r.i1 = a; r.i2 = c;
    exp_res.push_back(r);
  endtask

  task automatic wait_done(input int maxc);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", int'(seen), 1);
  endtask

  task automatic run(input logic [1:0] tgt, input int n);
    start = 1'b1;
    target_in = tgt;
    tick();
    start = 1'b0;
    chk("start_clears_found", int'(found), 0);
    for (int b = 0; b < n; b++) begin
      chk("beat_consecutive", int'(number_valid), 1);
      tick();
    end
    chk("valid_after_last", int'(number_valid), 0);
    wait_done(12);
  endtask

  initial begin
    rst = 1'b1;
    load_data = '0;
    load_valid = 1'b0;
    load_last = 1'b0;
    start = 1'b0;
    target_in = '0;
    set_hits(-1, 2'd0, 2'd0, -1, 2'd0, 2'd0);
    #3 rst = 1'b0;
    #10;
    chk("rst_valid", int'(number_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_target", int'(target), 0);
    chk("rst_length", int'(length), 0);
    chk("rst_index1", int'(result_index1), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Start before any load is ignored
    start = 1'b1;
    target_in = 2'b01;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("noload_busy", int'(busy), 0);

    // [1,0,-2,-1], target 1: solver reports 1/0 on the second beat
    load_elem(2'b01, 1'b0);
    load_elem(2'b00, 1'b0);
    load_elem(2'b10, 1'b0);
    load_elem(2'b11, 1'b1);
    chk("len_loadlast", int'(length), 4);
    set_hits(1, 2'd1, 2'd0, -1, 2'd0, 2'd0);
    push_beat(2'b01, 1'b0, 2'b01);
    push_beat(2'b00, 1'b0, 2'b01);
    push_beat(2'b10, 1'b0, 2'b01);
    push_beat(2'b11, 1'b1, 2'b01);
    push_res(1'b1, 2'd1, 2'd0);
    run(2'b01, 4);
    chk("early_exit_cycles", done_cyc - last_cyc, 2);
    tick();
    tick();
    chk("hold_found", int'(found), 1);
    chk("hold_index1", int'(result_index1), 1);

    // Replay with target -1: two results offered, only the first latched
    set_hits(1, 2'd2, 2'd0, 2, 2'd3, 2'd1);
    push_beat(2'b01, 1'b0, 2'b11);
    push_beat(2'b00, 1'b0, 2'b11);
    push_beat(2'b10, 1'b0, 2'b11);
    push_beat(2'b11, 1'b1, 2'b11);
    push_res(1'b1, 2'd2, 2'd0);
    run(2'b11, 4);
    tick();

    // [1,1,1,1] filled to capacity without load_last, no result
    set_hits(-1, 2'd0, 2'd0, -1, 2'd0, 2'd0);
    for (int i = 0; i < 4; i++) load_elem(2'b01, 1'b0);
    chk("len_full", int'(length), 4);
    for (int i = 0; i < 4; i++) push_beat(2'b01, i == 3, 2'b10);
    push_res(1'b0, 2'd0, 2'd0);
    run(2'b10, 4);
    chk("timeout_cycles", done_cyc - last_cyc, 3);
    tick();

    // Load and start in the same cycle: element stored, start dropped
    load_valid = 1'b1;
    load_data = 2'b00;
    load_last = 1'b1;
    start = 1'b1;
    target_in = 2'b01;
    tick();
    load_valid = 1'b0;
    load_last = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    chk("collide_busy", int'(busy), 0);
    chk("len_single", int'(length), 1);

    // Single element [0], target 0
    push_beat(2'b00, 1'b1, 2'b00);
    push_res(1'b0, 2'd0, 2'd0);
    run(2'b00, 1);
    chk("single_wait_cycles", done_cyc - last_cyc, 3);
    tick();

    // Asynchronous reset during the second beat
    load_elem(2'b01, 1'b0);
    load_elem(2'b00, 1'b0);
    load_elem(2'b10, 1'b0);
    load_elem(2'b11, 1'b1);
    set_hits(0, 2'd1, 2'd1, -1, 2'd0, 2'd0);
    push_beat(2'b01, 1'b0, 2'b01);
    push_beat(2'b00, 1'b0, 2'b01);
    start = 1'b1;
    target_in = 2'b01;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_found", int'(found), 1);
    #2 rst = 1'b0;
    #1;
    exp_beats.delete();
    chk("arst_valid", int'(number_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_found", int'(found), 0);
    chk("arst_length", int'(length), 0);
    set_hits(-1, 2'd0, 2'd0, -1, 2'd0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("post_rst_busy", int'(busy), 0);

    repeat (2) tick();
    chk("beats_left", exp_beats.size(), 0);
    chk("results_left", exp_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
